// File: rtl/fan_mode_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fan_mode_ctrl                                              |
// | Description : Fan mode/speed controller. Sequences the gear (D), the     |
// |               registered temperature (Tem) and the countdown timer       |
// |               (Time), and drives the fan PWM with duty D/4.              |
// |               Optional overheat trip enabled by macro FAN_OVERHEAT_EN.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fan_mode_ctrl #(
    parameter int TICK_DIV = 1000,   // clk cycles per timer minute (>= 2)
    parameter int TEM_LO   = 25,     // AUTO threshold gear 1 / gear 2
    parameter int TEM_HI   = 30,     // AUTO threshold gear 2 / gear 3
    parameter int TIME_MAX = 60,     // timer saturation value
    parameter int TEM_TRIP = 45      // overheat threshold (FAN_OVERHEAT_EN)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw,
    input  logic       key_gear,
    input  logic       key_mode,
    input  logic       key_time,
    input  logic [5:0] tem_in,
    output logic [2:0] D,
    output logic [5:0] Tem,
    output logic [5:0] Time,
    output logic       fan_pwm,
    output logic       alarm
);

    localparam int         c_TICK_W   = $clog2(TICK_DIV);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [5:0] c_TEM_LO   = 6'(TEM_LO);
    localparam logic [5:0] c_TEM_HI   = 6'(TEM_HI);
    localparam logic [6:0] c_TIME_MAX = 7'(TIME_MAX);

    localparam logic [1:0] c_ST_OFF    = 2'd0;
    localparam logic [1:0] c_ST_MANUAL = 2'd1;
    localparam logic [1:0] c_ST_AUTO   = 2'd2;

    logic [1:0]          r_state;
    logic [2:0]          r_d;
    logic [5:0]          r_tem;
    logic [5:0]          r_time;
    logic [c_TICK_W-1:0] r_tick;
    logic [1:0]          r_pwm_cnt;
    logic                r_pwm;
    logic                r_alarm;

    logic [6:0]          w_time_sum;
    logic [5:0]          w_time_add;
    logic [2:0]          w_auto_d;
    logic                w_trip;

    // Timer add is done one bit wider so +10 never wraps before saturation.
    assign w_time_sum = {1'b0, r_time} + 7'd10;
    assign w_time_add = (w_time_sum > c_TIME_MAX) ? c_TIME_MAX[5:0] : w_time_sum[5:0];

    // AUTO gear mapping uses the registered temperature, hence 2-cycle lag.
    assign w_auto_d = (r_tem < c_TEM_LO) ? 3'd1 :
                      (r_tem < c_TEM_HI) ? 3'd2 : 3'd3;

`ifdef FAN_OVERHEAT_EN
    localparam logic [5:0] c_TEM_TRIP = 6'(TEM_TRIP);
    assign w_trip = (r_tem >= c_TEM_TRIP);
`else
    logic [5:0] w_trip_unused;
    assign w_trip_unused = 6'(TEM_TRIP);
    assign w_trip        = 1'b0;
`endif

    // Mode FSM, gear, timer, temperature register and PWM generator.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_OFF;
            r_d       <= 3'd0;
            r_tem     <= 6'd0;
            r_time    <= 6'd0;
            r_tick    <= '0;
            r_pwm_cnt <= 2'd0;
            r_pwm     <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_tem     <= tem_in;
            r_pwm_cnt <= r_pwm_cnt + 2'd1;
            r_pwm     <= ({1'b0, r_pwm_cnt} < r_d);

            if (!sw) begin
                r_state <= c_ST_OFF;
                r_d     <= 3'd0;
                r_time  <= 6'd0;
                r_tick  <= '0;
                r_alarm <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_MANUAL, c_ST_AUTO: begin
                        // Gear / mode handling; key_mode beats key_gear.
                        if (key_mode) begin
                            r_state <= (r_state == c_ST_MANUAL) ? c_ST_AUTO : c_ST_MANUAL;
                        end else if (r_state == c_ST_AUTO) begin
                            r_d <= w_auto_d;
                        end else if (key_gear && !r_alarm) begin
                            r_d <= (r_d == 3'd3) ? 3'd1 : r_d + 3'd1;
                        end

                        // Overheat overrides whatever gear was chosen above.
                        if (w_trip) begin
                            r_d     <= 3'd3;
                            r_alarm <= 1'b1;
                        end else begin
                            r_alarm <= 1'b0;
                        end

                        // Timer: an add wins over a coincident tick.
                        if (key_time) begin
                            r_time <= w_time_add;
                            r_tick <= '0;
                        end else if (r_time != 6'd0) begin
                            if (r_tick == c_TICK_LAST) begin
                                r_tick <= '0;
                                r_time <= r_time - 6'd1;
                                if (r_time == 6'd1) begin
                                    r_state <= c_ST_OFF;
                                    r_d     <= 3'd0;
                                    r_alarm <= 1'b0;
                                end
                            end else begin
                                r_tick <= r_tick + 1'b1;
                            end
                        end else begin
                            r_tick <= '0;
                        end
                    end
                    default: begin
                        // OFF: keys ignored, power-on enters MANUAL at gear 1.
                        r_state <= c_ST_MANUAL;
                        r_d     <= 3'd1;
                        r_time  <= 6'd0;
                        r_tick  <= '0;
                        r_alarm <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign D       = r_d;
    assign Tem     = r_tem;
    assign Time    = r_time;
    assign fan_pwm = r_pwm;
    assign alarm   = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_fan_mode_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fan_mode_ctrl                                           |
// | Description : Directed self-checking bench for fan_mode_ctrl with        |
// |               TICK_DIV=4 and hand-computed expected values.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fan_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw;
    logic       key_gear;
    logic       key_mode;
    logic       key_time;
    logic [5:0] tem_in;
    logic [2:0] D;
    logic [5:0] Tem;
    logic [5:0] Time;
    logic       fan_pwm;
    logic       alarm;

    int n_tests = 0;
    int n_fail  = 0;

    fan_mode_ctrl #(
        .TICK_DIV (4)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .key_gear (key_gear),
        .key_mode (key_mode),
        .key_time (key_time),
        .tem_in   (tem_in),
        .D        (D),
        .Tem      (Tem),
        .Time     (Time),
        .fan_pwm  (fan_pwm),
        .alarm    (alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Advance n rising edges; outputs are then sampled 1 time unit later.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic duty(input string tag, input int exp);
        int cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            cnt += int'(fan_pwm);
        end
        check(tag, cnt, exp);
    endtask

    initial begin
        rst = 1'b1; sw = 1'b0; key_gear = 1'b0; key_mode = 1'b0;
        key_time = 1'b0; tem_in = 6'd0;

        // Reset
        step(2);
        check("rst_D", int'(D), 0);
        check("rst_Time", int'(Time), 0);
        check("rst_pwm", int'(fan_pwm), 0);
        check("rst_alarm", int'(alarm), 0);
        check("rst_Tem", int'(Tem), 0);
        rst = 1'b0; sw = 1'b1;
        step(1);
        check("pwron_D", int'(D), 1);
        tem_in = 6'd20;
        step(1);
        check("Tem_latch", int'(Tem), 20);

        // Manual wrap with PWM duty
        key_gear = 1'b1; step(1); key_gear = 1'b0;
        check("gear_2", int'(D), 2);
        duty("duty_2", 2);
        key_gear = 1'b1; step(1); key_gear = 1'b0;
        check("gear_3", int'(D), 3);
        duty("duty_3", 3);
        key_gear = 1'b1; step(1); key_gear = 1'b0;
        check("gear_wrap", int'(D), 1);
        duty("duty_1", 1);

        // AUTO mode
        key_mode = 1'b1; step(1); key_mode = 1'b0;
        check("auto_enter", int'(D), 1);
        tem_in = 6'd28;
        step(1);
        check("auto_lag", int'(D), 1);
        step(1);
        check("auto_28", int'(D), 2);
        key_gear = 1'b1; step(1); key_gear = 1'b0;
        check("auto_gear_ign", int'(D), 2);
        tem_in = 6'd33;
        step(2);
        check("auto_33", int'(D), 3);
        key_mode = 1'b1; step(1); key_mode = 1'b0;
        check("manual_hold", int'(D), 3);
        tem_in = 6'd20;
        step(3);
        check("manual_stay", int'(D), 3);
        key_gear = 1'b1; step(1); key_gear = 1'b0;
        check("manual_again", int'(D), 1);
        key_gear = 1'b1; step(1); key_gear = 1'b0;
        check("gear_2b", int'(D), 2);

        // Timer saturation
        for (int k = 1; k <= 7; k++) begin
            key_time = 1'b1; step(1);
            check($sformatf("time_add%0d", k), int'(Time), (k * 10 > 60) ? 60 : k * 10);
        end
        key_time = 1'b0;

        // sw=0 beats key_gear
        sw = 1'b0; key_gear = 1'b1; step(1);
        check("sw_off_D", int'(D), 0);
        check("sw_off_Time", int'(Time), 0);
        sw = 1'b1; key_gear = 1'b0; step(1);
        check("sw_on_D", int'(D), 1);

        // Timer expiry from 10 minutes (4 cycles per minute)
        key_time = 1'b1; step(1); key_time = 1'b0;
        check("exp_start", int'(Time), 10);
        step(3);
        check("exp_hold", int'(Time), 10);
        step(1);
        check("exp_dec", int'(Time), 9);
        step(35);
        check("exp_one", int'(Time), 1);
        check("exp_one_D", int'(D), 1);
        step(1);
        check("exp_zero", int'(Time), 0);
        check("exp_off_D", int'(D), 0);
        step(1);
        check("exp_reenter", int'(D), 1);

        // key_time coincident with terminal count at Time=5
        key_time = 1'b1; step(1); key_time = 1'b0;
        step(23);
        check("coin_pre", int'(Time), 5);
        key_time = 1'b1; step(1); key_time = 1'b0;
        check("coin_add", int'(Time), 15);
        step(3);
        check("coin_hold", int'(Time), 15);
        step(1);
        check("coin_dec", int'(Time), 14);

        // key_gear + key_mode together in MANUAL at D=1
        key_gear = 1'b1; key_mode = 1'b1; step(1);
        key_gear = 1'b0; key_mode = 1'b0;
        check("both_keys_D", int'(D), 1);
        tem_in = 6'd33;
        step(2);
        check("both_keys_auto", int'(D), 3);

        // Overheat
        key_mode = 1'b1; step(1); key_mode = 1'b0;
        check("oh_manual", int'(D), 3);
        tem_in = 6'd20;
        key_gear = 1'b1; step(1); key_gear = 1'b0;
        check("oh_d1", int'(D), 1);
        tem_in = 6'd50;
        step(1);
        check("oh_lag", int'(D), 1);
        step(1);
`ifdef FAN_OVERHEAT_EN
        check("oh_trip_D", int'(D), 3);
        check("oh_trip_alarm", int'(alarm), 1);
        key_gear = 1'b1; step(1); key_gear = 1'b0;
        check("oh_gear_ign", int'(D), 3);
        tem_in = 6'd20;
        step(1);
        check("oh_alarm_lag", int'(alarm), 1);
        step(1);
        check("oh_clear_alarm", int'(alarm), 0);
        check("oh_clear_D", int'(D), 3);
`else
        check("noh_D", int'(D), 1);
        check("noh_alarm", int'(alarm), 0);
        key_gear = 1'b1; step(1); key_gear = 1'b0;
        check("noh_gear", int'(D), 2);
        tem_in = 6'd20;
        step(2);
        check("noh_alarm2", int'(alarm), 0);
        check("noh_D2", int'(D), 2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
